// File: rtl/spi_slave_frame_responder.sv
// SPI mode-0 responder: oversamples spi_clk/spi_cs_n/spi_mosi in sys_clk,
// deserialises {rd_addr, wr_addr, data} MSB first, fetches a read word
// mid-frame to shift out on spi_miso, and writes the captured fields at
// frame end.
// Optional: define SPI_SLV_FRAME_ERR_EN to add the frame_err output and
// overflow tracking (overlong frames then do not write).
module spi_slave_frame_responder #(
    parameter int SPI_RD_ADDR_WIDTH = 4,
    parameter int SPI_WR_ADDR_WIDTH = 4,
    parameter int SPI_DATA_WIDTH    = 32,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    input  logic                         spi_clk,
    input  logic                         spi_cs_n,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    output logic                         rd_req,
    output logic [SPI_RD_ADDR_WIDTH-1:0] rd_addr,
    input  logic                         rd_valid,
    input  logic [SPI_DATA_WIDTH-1:0]    rd_data,
    output logic                         wr_en,
    output logic [SPI_WR_ADDR_WIDTH-1:0] wr_addr,
    output logic [SPI_DATA_WIDTH-1:0]    wr_data,
    output logic                         rd_miss
`ifdef SPI_SLV_FRAME_ERR_EN
    ,
    output logic                         frame_err
`endif
);

    localparam int FRAME_BITS = SPI_RD_ADDR_WIDTH + SPI_WR_ADDR_WIDTH + SPI_DATA_WIDTH;
    localparam int CW         = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] RD_LAST    = CW'(SPI_RD_ADDR_WIDTH - 1);
    localparam logic [CW-1:0] ADDR_LAST  = CW'(SPI_RD_ADDR_WIDTH + SPI_WR_ADDR_WIDTH - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] FRAME_END  = CW'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                    state, state_nxt;
    logic [SYNC_STAGES-1:0]    clk_sync, cs_sync, mosi_sync;
    logic [CW-1:0]             cnt;
    logic [FRAME_BITS-1:0]     rx, rx_shift;
    logic [SPI_DATA_WIDTH-1:0] tx;
    logic                      tx_vld, tx_first, rd_win;
    logic                      clk_rise, clk_fall, cs_rise, cs_fall, mosi_bit;
    logic                      rd_fire, wr_fire, rd_accept;
`ifdef SPI_SLV_FRAME_ERR_EN
    logic                      ovf, ferr_fire;
`endif

    // Edges come from the two oldest synchronised samples; mosi is stable
    // for many sys_clk cycles around the rise so its oldest sample is used.
    assign clk_rise  =  clk_sync[SYNC_STAGES-2] & ~clk_sync[SYNC_STAGES-1];
    assign clk_fall  = ~clk_sync[SYNC_STAGES-2] &  clk_sync[SYNC_STAGES-1];
    assign cs_fall   = ~cs_sync[SYNC_STAGES-2]  &  cs_sync[SYNC_STAGES-1];
    assign cs_rise   =  cs_sync[SYNC_STAGES-2]  & ~cs_sync[SYNC_STAGES-1];
    assign mosi_bit  = mosi_sync[SYNC_STAGES-1];
    assign rx_shift  = {rx[FRAME_BITS-2:0], mosi_bit};
    // Read data is taken once per frame, only until the first data-phase fall.
    assign rd_accept = rd_win & rd_valid & ~tx_vld & ~((state == DATA) & clk_fall);

    // Input synchronisers; cs_n resets low so a chip select already held
    // low across reset is not mistaken for a fresh falling edge.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            clk_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    // Frame sequencing plus the read/write/error strobe decisions.
    always_comb begin
        state_nxt = state;
        rd_fire   = 1'b0;
        wr_fire   = 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
        ferr_fire = 1'b0;
`endif
        case (state)
            IDLE: if (cs_fall) state_nxt = ADDR;
            ADDR: begin
                if (cs_rise) state_nxt = IDLE;
                else if (clk_rise) begin
                    if (cnt == RD_LAST)   rd_fire   = 1'b1;
                    if (cnt == ADDR_LAST) state_nxt = DATA;
                end
            end
            DATA: begin
                if (cs_rise) state_nxt = IDLE;
                else if (clk_rise && cnt == FRAME_LAST) state_nxt = DONE;
            end
            DONE: if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cs_rise && state != IDLE) begin
`ifdef SPI_SLV_FRAME_ERR_EN
            wr_fire   = (cnt == FRAME_END) & ~ovf;
            ferr_fire = (cnt != FRAME_END) | ovf;
`else
            wr_fire   = (cnt == FRAME_END);
`endif
        end
    end

    // State register and datapath: shifting, read capture, miso drive, strobes.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rx       <= '0;
            tx       <= '0;
            tx_vld   <= 1'b0;
            tx_first <= 1'b0;
            rd_win   <= 1'b0;
            spi_miso <= 1'b0;
            rd_req   <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_miss  <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
            ovf       <= 1'b0;
            frame_err <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            rd_req  <= rd_fire;
            wr_en   <= wr_fire;
            rd_miss <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
            frame_err <= ferr_fire;
`endif
            if (rd_fire) begin
                rd_addr <= rx_shift[SPI_RD_ADDR_WIDTH-1:0];
                rd_win  <= 1'b1;
            end
            if (wr_fire) begin
                wr_addr <= rx[SPI_DATA_WIDTH +: SPI_WR_ADDR_WIDTH];
                wr_data <= rx[SPI_DATA_WIDTH-1:0];
            end
            if (rd_accept) begin
                tx     <= rd_data;
                tx_vld <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        cnt      <= '0;
                        rx       <= '0;
                        tx       <= '0;
                        tx_vld   <= 1'b0;
                        tx_first <= 1'b1;
                        rd_win   <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
                        ovf      <= 1'b0;
`endif
                    end
                end
                ADDR, DATA: begin
                    if (!cs_rise) begin
                        if (clk_rise) begin
                            rx  <= rx_shift;
                            cnt <= cnt + CW'(1);
                        end
                        if (state == DATA && clk_fall) begin
                            if (tx_first && !tx_vld) begin
                                // No read word in time: flag it and send zeros.
                                tx_first <= 1'b0;
                                rd_win   <= 1'b0;
                                rd_miss  <= 1'b1;
                                spi_miso <= 1'b0;
                                tx       <= '0;
                            end else begin
                                tx_first <= 1'b0;
                                rd_win   <= 1'b0;
                                spi_miso <= tx[SPI_DATA_WIDTH-1];
                                tx       <= tx << 1;
                            end
                        end
                    end
                end
                DONE: begin
`ifdef SPI_SLV_FRAME_ERR_EN
                    if (clk_rise && !cs_rise) ovf <= 1'b1;
`endif
                end
                default: ;
            endcase
            // End of frame (normal or aborted) drops any pending read.
            if (cs_rise && state != IDLE) begin
                spi_miso <= 1'b0;
                rd_win   <= 1'b0;
                tx_vld   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_frame_responder.sv
// Scoreboard bench for spi_slave_frame_responder: a mode-0 SPI master task
// drives frames, a responder answers rd_req, and monitors pop expected
// read addresses / writes from queues as the DUT strobes them.
module tb_spi_slave_frame_responder;

    localparam int H = 8;   // spi_clk half period in sys_clk cycles

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data = '0;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_miss;
`ifdef SPI_SLV_FRAME_ERR_EN
    logic        frame_err;
`endif

    int n_chk = 0;
    int n_err = 0;
    int rdreq_n = 0, wr_n = 0, miss_n = 0, ferr_n = 0;
    logic [3:0]  rd_q[$];
    logic [35:0] wr_q[$];
    logic [31:0] miso_q[$];
    bit          resp_en = 1'b1;
    logic [31:0] resp_word = '0;

    spi_slave_frame_responder dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .spi_clk  (spi_clk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_miss  (rd_miss)
`ifdef SPI_SLV_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Monitor: strobes are sampled mid-cycle and matched against the scoreboard.
    always @(negedge sys_clk) begin
        if (rd_req) begin
            rdreq_n++;
            if (rd_q.size() == 0) chk("rd_req_extra", 1, 0);
            else chk("rd_addr", rd_addr, rd_q.pop_front());
        end
        if (wr_en) begin
            wr_n++;
            if (wr_q.size() == 0) chk("wr_en_extra", 1, 0);
            else chk("wr_fields", {wr_addr, wr_data}, wr_q.pop_front());
        end
        if (rd_miss) miss_n++;
`ifdef SPI_SLV_FRAME_ERR_EN
        if (frame_err) ferr_n++;
`endif
    end

    // Register-file model: answers each rd_req two cycles later when enabled.
    initial begin
        forever begin
            cyc(1);
            if (rd_req && resp_en) begin
                cyc(2);
                rd_valid = 1'b1;
                rd_data  = resp_word;
                cyc(1);
                rd_valid = 1'b0;
            end
        end
    end

    // Mode-0 master; optionally pulses reset after the fall of bit rst_at.
    task automatic frame(input logic [39:0] bits, input int nclk, input int rst_at,
                         input bit chk_miso);
        logic [31:0] w;
        w = '0;
        spi_cs_n = 1'b0;
        cyc(H);
        for (int i = 0; i < nclk; i++) begin
            spi_mosi = (i < 40) ? bits[39-i] : 1'b1;
            cyc(H);
            if (i >= 8 && i < 40) w = {w[30:0], spi_miso};
            spi_clk = 1'b1;
            cyc(H);
            spi_clk = 1'b0;
            if (i == rst_at) begin
                reset_n = 1'b0;
                cyc(1);
                reset_n = 1'b1;
                chk("rst_mid_outs", {spi_miso, rd_req, rd_miss, wr_en, rd_addr, wr_addr, wr_data}, 0);
            end
        end
        cyc(H);
        spi_cs_n = 1'b1;
        cyc(H);
        if (chk_miso) chk("miso_word", w, miso_q.pop_front());
    endtask

    task automatic expect_counts(input string t, input int r, input int w, input int m, input int f);
        cyc(4 * H);
        chk({t, "_rd_req"}, rdreq_n, r);
        chk({t, "_wr_en"}, wr_n, w);
        chk({t, "_rd_miss"}, miss_n, m);
`ifdef SPI_SLV_FRAME_ERR_EN
        chk({t, "_frame_err"}, ferr_n, f);
`else
        if (f < 0) chk({t, "_frame_err"}, ferr_n, 0);
`endif
        rdreq_n = 0; wr_n = 0; miss_n = 0; ferr_n = 0;
        rd_q.delete(); wr_q.delete(); miso_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        cyc(5);
        chk("reset_outs", {spi_miso, rd_req, rd_miss, wr_en, rd_addr, wr_addr, wr_data}, 0);
        reset_n = 1'b1;
        cyc(5);

        // Full frame with a timely read.
        resp_en = 1'b1; resp_word = 32'h12345678;
        rd_q.push_back(4'h3); wr_q.push_back({4'hA, 32'hDEADBEEF}); miso_q.push_back(32'h12345678);
        frame({4'h3, 4'hA, 32'hDEADBEEF}, 40, -1, 1'b1);
        expect_counts("full", 1, 1, 0, 0);

        // Same frame, read never answered.
        resp_en = 1'b0;
        rd_q.push_back(4'h3); wr_q.push_back({4'hA, 32'hDEADBEEF}); miso_q.push_back(32'h0);
        frame({4'h3, 4'hA, 32'hDEADBEEF}, 40, -1, 1'b1);
        expect_counts("miss", 1, 1, 1, 0);

        // Abort after 20 bits, then a clean frame.
        resp_en = 1'b1; resp_word = 32'hCAFEF00D;
        rd_q.push_back(4'h7);
        frame({4'h7, 4'h2, 32'h55555555}, 20, -1, 1'b0);
        expect_counts("abort", 1, 0, 0, 1);
        rd_q.push_back(4'h1); wr_q.push_back({4'h5, 32'h1}); miso_q.push_back(32'hCAFEF00D);
        frame({4'h1, 4'h5, 32'h1}, 40, -1, 1'b1);
        expect_counts("after_abort", 1, 1, 0, 0);

        // 42-clock frame.
        resp_word = 32'h89ABCDEF;
        rd_q.push_back(4'h9); miso_q.push_back(32'h89ABCDEF);
`ifdef SPI_SLV_FRAME_ERR_EN
        frame({4'h9, 4'hC, 32'hA5A50F0F}, 42, -1, 1'b1);
        expect_counts("long", 1, 0, 0, 1);
`else
        wr_q.push_back({4'hC, 32'hA5A50F0F});
        frame({4'h9, 4'hC, 32'hA5A50F0F}, 42, -1, 1'b1);
        expect_counts("long", 1, 1, 0, 0);
`endif

        // Reset at bit 30, clocks continue with cs_n low; then a normal frame.
        resp_word = 32'h0F0F1234;
        rd_q.push_back(4'h6);
        frame({4'h6, 4'h3, 32'h77778888}, 40, 30, 1'b0);
        expect_counts("reset_mid", 1, 0, 0, 0);
        resp_word = 32'hFEEDFACE;
        rd_q.push_back(4'hE); wr_q.push_back({4'h4, 32'h0BADCAFE}); miso_q.push_back(32'hFEEDFACE);
        frame({4'hE, 4'h4, 32'h0BADCAFE}, 40, -1, 1'b1);
        expect_counts("post_reset", 1, 1, 0, 0);

        // Back-to-back frames, 4 spi_clk periods apart.
        resp_word = 32'h00C0FFEE;
        rd_q.push_back(4'h2); wr_q.push_back({4'hB, 32'h13579BDF}); miso_q.push_back(32'h00C0FFEE);
        rd_q.push_back(4'hD); wr_q.push_back({4'h8, 32'h2468ACE0}); miso_q.push_back(32'h00C0FFEE);
        frame({4'h2, 4'hB, 32'h13579BDF}, 40, -1, 1'b1);
        cyc(7 * H);
        frame({4'hD, 4'h8, 32'h2468ACE0}, 40, -1, 1'b1);
        expect_counts("b2b", 2, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
